// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants, RGB565 colours, the renderer palette and the motion FSM states
package vga_pkg;
  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] ORANGE  = 16'hFD20;
  localparam logic [15:0] PALETTE [8] = '{WHITE, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, ORANGE};
  typedef enum logic {RUN, PAUSE} run_state_t;
endpackage

// File: rtl/vga_axis_bounce.sv
// vga_axis_bounce: one-axis stepper that moves an origin by step and bounces at 0 and max
//   org/dir      current origin and direction (1 = increasing)
//   step/max     move size and upper limit of the origin
//   en           apply a move this cycle; otherwise org/dir pass through
//   nxt_org/nxt_dir/bounce  next origin, next direction, edge hit this move
module vga_axis_bounce (
  input  logic [9:0] org,
  input  logic       dir,
  input  logic [3:0] step,
  input  logic [9:0] max,
  input  logic       en,
  output logic [9:0] nxt_org,
  output logic       nxt_dir,
  output logic       bounce
);
  logic [10:0] sum;
  logic        hit_max;
  logic        hit_min;
  assign sum     = {1'b0, org} + {7'd0, step};
  assign hit_max = dir && sum >= {1'b0, max};
  assign hit_min = !dir && org <= {6'd0, step};
  assign bounce  = en && (hit_max || hit_min);
  assign nxt_org = !en ? org : hit_max ? max : hit_min ? 10'd0 : dir ? sum[9:0] : org - {6'd0, step};
  assign nxt_dir = bounce ? !dir : dir;
endmodule

// File: rtl/vga_text_motion_ctrl.sv
// vga_text_motion_ctrl: bouncing-block origin and palette colour controller, updated only in blanking
//   vga_clk/sys_rst_n        pixel clock, async active-low reset
//   pix_x/pix_y              active-pixel position from the timing generator
//   key_pause/key_color      debounced pulses: toggle RUN/PAUSE, advance palette
//   org_x/org_y/char_color   block origin and RGB565 foreground colour
//   frame_tick               one-cycle pulse after the last active pixel
//   run                      1 while moving
module vga_text_motion_ctrl
  import vga_pkg::*;
#(
  parameter int BLK_W     = 256,
  parameter int BLK_H     = 64,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        key_pause,
  input  logic        key_color,
  output logic [9:0]  org_x,
  output logic [9:0]  org_y,
  output logic [15:0] char_color,
  output logic        frame_tick,
  output logic        run
);
  localparam logic [9:0] MAX_X  = 10'(H_VALID - BLK_W);
  localparam logic [9:0] MAX_Y  = 10'(V_VALID - BLK_H);
  localparam logic [9:0] X0     = 10'((H_VALID - BLK_W) / 2);
  localparam logic [9:0] Y0     = 10'((V_VALID - BLK_H) / 2);
  localparam logic [3:0] STP    = 4'(STEP);
  localparam logic [7:0] DIV_M1 = 8'(FRAME_DIV - 1);
  run_state_t state, state_n;
  logic [9:0] org_x_n, org_y_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [2:0] pal_idx, pal_idx_n;
  logic       dx, dy, dx_n, dy_n, bx, by, upd, eof;
  logic       pause_pend, pause_pend_n, color_pend, color_pend_n;
  assign eof = pix_x == 10'(H_VALID - 1) && pix_y == 10'(V_VALID - 1);
  assign upd = frame_tick && state == RUN && frame_cnt == DIV_M1;
  vga_axis_bounce u_ax (
    .org(org_x), .dir(dx), .step(STP), .max(MAX_X), .en(upd),
    .nxt_org(org_x_n), .nxt_dir(dx_n), .bounce(bx)
  );
  vga_axis_bounce u_ay (
    .org(org_y), .dir(dy), .step(STP), .max(MAX_Y), .en(upd),
    .nxt_org(org_y_n), .nxt_dir(dy_n), .bounce(by)
  );
  // A key landing on the tick cycle itself survives into the next frame's pending flag.
  always_comb begin
    state_n      = (frame_tick && pause_pend) ? (state == RUN ? PAUSE : RUN) : state;
    frame_cnt_n  = (frame_tick && state == RUN) ? (upd ? 8'd0 : frame_cnt + 8'd1) : frame_cnt;
    pause_pend_n = frame_tick ? key_pause : pause_pend | key_pause;
    color_pend_n = frame_tick ? key_color : color_pend | key_color;
    pal_idx_n    = pal_idx + 3'(frame_tick && (bx || by || color_pend));
  end
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state      <= RUN;
      frame_cnt  <= '0;
      pause_pend <= 1'b0;
      color_pend <= 1'b0;
      pal_idx    <= '0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      org_x      <= X0;
      org_y      <= Y0;
      char_color <= WHITE;
      frame_tick <= 1'b0;
      run        <= 1'b1;
    end else begin
      state      <= state_n;
      frame_cnt  <= frame_cnt_n;
      pause_pend <= pause_pend_n;
      color_pend <= color_pend_n;
      pal_idx    <= pal_idx_n;
      dx         <= dx_n;
      dy         <= dy_n;
      org_x      <= org_x_n;
      org_y      <= org_y_n;
      char_color <= PALETTE[pal_idx_n];
      frame_tick <= eof;
      run        <= state_n == RUN;
    end
endmodule

// File: tb/tb_vga_text_motion_ctrl.sv
// tb_vga_text_motion_ctrl: directed bench for motion, bounce, pause, palette and reset behaviour
module tb_vga_text_motion_ctrl;
  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        key_pause = 1'b0, key_color = 1'b0;
  logic [9:0]  org_x, org_y, org_x3, org_y3;
  logic [15:0] char_color, char_color3;
  logic        frame_tick, frame_tick3, run, run3;
  logic        ft_pre, ft_on, ft_post;
  logic [9:0]  ox_on, oy_on;
  int          n_chk = 0, n_pass = 0, nf = 0;
  always #5 vga_clk = ~vga_clk;
  vga_text_motion_ctrl dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_pause(key_pause), .key_color(key_color), .org_x(org_x), .org_y(org_y),
    .char_color(char_color), .frame_tick(frame_tick), .run(run)
  );
  vga_text_motion_ctrl #(.FRAME_DIV(3)) dut3 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_pause(key_pause), .key_color(key_color), .org_x(org_x3), .org_y(org_y3),
    .char_color(char_color3), .frame_tick(frame_tick3), .run(run3)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // One shortened frame: an active pixel, the last active pixel, then blanking.
  task automatic frame(input logic kp, input logic kc, input logic kt);
    pix_x = 10'd100; pix_y = 10'd100; key_pause = kp; key_color = kc;
    @(posedge vga_clk); #1;
    key_pause = 1'b0; key_color = 1'b0; pix_x = 10'd639; pix_y = 10'd479;
    ft_pre = frame_tick;
    @(posedge vga_clk); #1;
    pix_x = 10'd0; pix_y = 10'd480; key_color = kt;
    ft_on = frame_tick; ox_on = org_x; oy_on = org_y;
    @(posedge vga_clk); #1;
    key_color = 1'b0; ft_post = frame_tick;
    nf++;
  endtask
  task automatic run_to(input int n);
    while (nf < n) frame(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (2) @(posedge vga_clk);
    #1;
    chk("rst_org_x", 16'(org_x), 16'd192);
    chk("rst_org_y", 16'(org_y), 16'd208);
    chk("rst_color", char_color, 16'hFFFF);
    chk("rst_run", 16'(run), 16'd1);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    sys_rst_n = 1'b1;
    @(posedge vga_clk); #1;
    frame(1'b0, 1'b0, 1'b0);
    chk("f1_tick_pre", 16'(ft_pre), 16'd0);
    chk("f1_tick_on", 16'(ft_on), 16'd1);
    chk("f1_tick_post", 16'(ft_post), 16'd0);
    chk("f1_org_x_on_tick", 16'(ox_on), 16'd192);
    chk("f1_org_y_on_tick", 16'(oy_on), 16'd208);
    chk("f1_org_x", 16'(org_x), 16'd193);
    chk("f1_org_y", 16'(org_y), 16'd209);
    chk("f1_color", char_color, 16'hFFFF);
    chk("d3_f1_org_x", 16'(org_x3), 16'd192);
    frame(1'b0, 1'b0, 1'b0);
    chk("d3_f2_org_x", 16'(org_x3), 16'd192);
    frame(1'b0, 1'b0, 1'b0);
    chk("d3_f3_org_x", 16'(org_x3), 16'd193);
    chk("f3_org_x", 16'(org_x), 16'd195);
    run_to(192);
    chk("f192_org_x", 16'(org_x), 16'd384);
    chk("f192_color", char_color, 16'hF800);
    chk("d3_f192_org_x", 16'(org_x3), 16'd256);
    chk("d3_f192_color", char_color3, 16'hFFFF);
    frame(1'b0, 1'b0, 1'b0);
    chk("f193_org_x", 16'(org_x), 16'd383);
    run_to(208);
    chk("f208_org_y", 16'(org_y), 16'd416);
    chk("f208_color", char_color, 16'h07E0);
    frame(1'b0, 1'b0, 1'b0);
    chk("f209_org_y", 16'(org_y), 16'd415);
    chk("f209_org_x", 16'(org_x), 16'd367);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    chk("pause_run", 16'(run), 16'd0);
    chk("pause_org_x", 16'(org_x), 16'd365);
    chk("pause_org_y", 16'(org_y), 16'd413);
    run_to(221);
    chk("frozen_org_x", 16'(org_x), 16'd365);
    chk("frozen_org_y", 16'(org_y), 16'd413);
    chk("frozen_run", 16'(run), 16'd0);
    chk("d3_frozen_org_x", 16'(org_x3), 16'd262);
    frame(1'b1, 1'b0, 1'b0);
    chk("resume_run", 16'(run), 16'd1);
    chk("resume_org_x", 16'(org_x), 16'd365);
    frame(1'b0, 1'b0, 1'b0);
    chk("f223_org_x", 16'(org_x), 16'd364);
    chk("d3_f223_org_x", 16'(org_x3), 16'd262);
    frame(1'b0, 1'b0, 1'b0);
    chk("d3_f224_org_x", 16'(org_x3), 16'd263);
    chk("d3_f224_org_y", 16'(org_y3), 16'd279);
    frame(1'b0, 1'b0, 1'b1);
    chk("key_on_tick_color", char_color, 16'h07E0);
    frame(1'b0, 1'b0, 1'b0);
    chk("key_held_color", char_color, 16'h001F);
    chk("f226_org_y", 16'(org_y), 16'd409);
    frame(1'b0, 1'b1, 1'b0);
    chk("key_mid_color", char_color, 16'hFFE0);
    force dut.org_x = 10'd383;
    force dut.org_y = 10'd415;
    force dut.dx = 1'b1;
    force dut.dy = 1'b1;
    @(posedge vga_clk); #1;
    release dut.org_x;
    release dut.org_y;
    release dut.dx;
    release dut.dy;
    frame(1'b0, 1'b1, 1'b0);
    chk("corner_org_x", 16'(org_x), 16'd384);
    chk("corner_org_y", 16'(org_y), 16'd416);
    chk("corner_color", char_color, 16'h07FF);
    frame(1'b0, 1'b0, 1'b0);
    chk("after_corner_org_x", 16'(org_x), 16'd383);
    chk("after_corner_org_y", 16'(org_y), 16'd415);
    chk("after_corner_color", char_color, 16'h07FF);
    pix_x = 10'd300; pix_y = 10'd100;
    @(posedge vga_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_org_x", 16'(org_x), 16'd192);
    chk("mid_rst_org_y", 16'(org_y), 16'd208);
    chk("mid_rst_color", char_color, 16'hFFFF);
    chk("mid_rst_run", 16'(run), 16'd1);
    repeat (3) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    frame(1'b0, 1'b0, 1'b0);
    chk("post_rst_org_x", 16'(org_x), 16'd193);
    chk("post_rst_org_y", 16'(org_y), 16'd209);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
